// File: rtl/sfp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfp_pkg
// Description : Shared types and constants for the sfp accumulator bank.
// Revision    : 1.0
// ============================================================================
package sfp_pkg;

    localparam int PSUM_BW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACC   = 3'd2,
        ST_RELU  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sfp_ctrl_if
// Description : Control, ofifo and psum-memory signals of the sfp sequencer.
// Revision    : 1.0
// ============================================================================
interface sfp_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic              relu_cfg;
    logic [ADDR_W-1:0] base_addr;
    logic              ofifo_valid;
    logic              ofifo_rd;
    logic              sfp_clr;
    logic              sfp_acc;
    logic              sfp_relu;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, relu_cfg, base_addr, ofifo_valid,
        input  ofifo_rd, sfp_clr, sfp_acc, sfp_relu, mem_wr_en, mem_wr_addr, busy, done
    );

    modport slave (
        input  start, relu_cfg, base_addr, ofifo_valid,
        output ofifo_rd, sfp_clr, sfp_acc, sfp_relu, mem_wr_en, mem_wr_addr, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sfp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sfp_ctrl
// Description : Per-pixel clear / accumulate / ReLU / write sequencer for one
//               column-bank of sfp accumulators.
// Revision    : 1.0
// ============================================================================
module sfp_ctrl
    import sfp_pkg::*;
#(
    parameter int NUM_TAPS = 9,
    parameter int NUM_PIX  = 16,
    parameter int ADDR_W   = 11
) (
    input  wire logic   clk,
    input  wire logic   reset,
    sfp_ctrl_if.slave   bus
);

    localparam int TAP_W = cnt_w(NUM_TAPS);
    localparam int PIX_W = cnt_w(NUM_PIX);
    localparam logic [TAP_W-1:0] C_TAP_LAST = TAP_W'(NUM_TAPS - 1);
    localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(NUM_PIX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TAP_W-1:0]  r_tap_cnt;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic              r_cfg_relu;
    logic [ADDR_W-1:0] r_cfg_base;

    logic w_pop;
    logic w_last_tap;
    logic w_last_pix;

    assign w_pop      = (r_state == ST_ACC) && bus.ofifo_valid;
    assign w_last_tap = w_pop && (r_tap_cnt == C_TAP_LAST);
    assign w_last_pix = (r_pix_cnt == C_PIX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_ACC;
            ST_ACC:   if (w_last_tap) w_state_nxt = r_cfg_relu ? ST_RELU : ST_WRITE;
            ST_RELU:  w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = w_last_pix ? ST_DONE : ST_CLEAR;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Tap count is rezeroed in CLEAR, so its wrap after the last pop is harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_cfg_relu <= 1'b0;
            r_cfg_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_cfg_relu <= bus.relu_cfg;
                        r_cfg_base <= bus.base_addr;
                        r_pix_cnt  <= '0;
                    end
                end
                ST_CLEAR: r_tap_cnt <= '0;
                ST_ACC:   if (w_pop) r_tap_cnt <= r_tap_cnt + TAP_W'(1);
                ST_WRITE: if (!w_last_pix) r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                default:  ;
            endcase
        end
    end

    // Everything except the ACC pop strobe is decoded from registered state.
    always_comb begin
        bus.ofifo_rd    = 1'b0;
        bus.sfp_clr     = 1'b0;
        bus.sfp_acc     = 1'b0;
        bus.sfp_relu    = 1'b0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.busy        = (r_state != ST_IDLE);
        bus.done        = 1'b0;
        case (r_state)
            ST_CLEAR: bus.sfp_clr = 1'b1;
            ST_ACC: begin
                bus.sfp_acc  = bus.ofifo_valid;
                bus.ofifo_rd = bus.ofifo_valid;
            end
            ST_RELU:  bus.sfp_relu = 1'b1;
            ST_WRITE: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = r_cfg_base + ADDR_W'(r_pix_cnt);
            end
            ST_DONE:  bus.done = 1'b1;
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sfp_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sfp_ctrl: per-pixel phase schedule model plus a
// bench-side sfp accumulator to check written data.
module tb_sfp_ctrl;
    import sfp_pkg::*;

    localparam int NT = 9;
    localparam int NP = 16;
    localparam int AW = 11;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sfp_ctrl_if #(.ADDR_W(AW)) bus ();
    sfp_ctrl_if #(.ADDR_W(AW)) bus1 ();

    sfp_ctrl #(.NUM_TAPS(NT), .NUM_PIX(NP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    sfp_ctrl #(.NUM_TAPS(1), .NUM_PIX(1), .ADDR_W(AW)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    typedef enum {K_CLR, K_ACC, K_RELU, K_WR, K_DONE} kind_e;
    typedef struct {
        kind_e          k;
        logic [AW-1:0]  addr;
    } tok_t;

    tok_t sched[$];
    int   fifo_q[$];
    int   exp_q[$];
    int   psum;
    int   cyc = 0;
    bit   gate_rand = 1'b0;
    bit   run_relu;
    int   n_wr, n_pop, pix_pops, acc_cyc, first_wr_cyc, done_cyc, first_wr_data;
    logic [AW-1:0] last_wr_addr;
    bit   done_seen;
    int   negv[NT] = '{10, -20, 5, -7, 3, -15, -8, 4, -9};

    function automatic logic [17:0] outv();
        return {bus.sfp_clr, bus.sfp_acc, bus.sfp_relu, bus.ofifo_rd,
                bus.mem_wr_en, bus.busy, bus.done, bus.mem_wr_addr};
    endfunction

    function automatic logic [17:0] outv1();
        return {bus1.sfp_clr, bus1.sfp_acc, bus1.sfp_relu, bus1.ofifo_rd,
                bus1.mem_wr_en, bus1.busy, bus1.done, bus1.mem_wr_addr};
    endfunction

    // Expected run: per pixel one clear, NT accepted pops, optional relu, one write; then done.
    task automatic build(input logic [AW-1:0] base, input bit relu);
        tok_t t;
        for (int p = 0; p < NP; p++) begin
            t.addr = '0;
            t.k = K_CLR; sched.push_back(t);
            for (int i = 0; i < NT; i++) begin
                t.k = K_ACC; sched.push_back(t);
            end
            if (relu) begin
                t.k = K_RELU; sched.push_back(t);
            end
            t.k = K_WR; t.addr = AW'(base + AW'(p)); sched.push_back(t);
        end
        t.k = K_DONE; t.addr = '0; sched.push_back(t);
    endtask

    // Environment and compare process: drives ofifo_valid, checks outputs every cycle.
    initial begin
        logic [6:0]    e;
        logic [AW-1:0] ea;
        int            v;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.ofifo_valid = (fifo_q.size() > 0) && (!gate_rand || ($urandom_range(0, 2) != 0));
            #1;
            if (!reset) begin
                chk("reset_outputs", 32'(outv()), 32'd0);
                sched.delete(); fifo_q.delete(); exp_q.delete();
                psum = 0; pix_pops = 0;
            end else begin
                e = '0; ea = '0;
                if (sched.size() > 0) begin
                    e[1] = 1'b1;
                    case (sched[0].k)
                        K_CLR:  e[6] = 1'b1;
                        K_ACC:  begin e[5] = bus.ofifo_valid; e[3] = bus.ofifo_valid; end
                        K_RELU: e[4] = 1'b1;
                        K_WR:   begin e[2] = 1'b1; ea = sched[0].addr; end
                        K_DONE: e[0] = 1'b1;
                        default: ;
                    endcase
                end
                chk("cycle_outputs", 32'(outv()), 32'({e, ea}));

                if (sched.size() > 0 && sched[0].k == K_WR) begin
                    v = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
                    if (run_relu && v < 0) v = 0;
                    chk("wr_data", psum, v);
                    if (n_wr == 0) begin
                        first_wr_cyc  = cyc;
                        first_wr_data = psum;
                    end
                    last_wr_addr = bus.mem_wr_addr;
                    n_wr++;
                end

                // Bench-side sfp lane reacting to the controller strobes.
                if (bus.sfp_clr) psum = 0;
                if (bus.sfp_acc && fifo_q.size() > 0) psum += fifo_q[0];
                if (bus.sfp_relu && psum < 0) psum = 0;
                if (bus.ofifo_rd && fifo_q.size() > 0) begin
                    void'(fifo_q.pop_front());
                    n_pop++;
                    pix_pops++;
                end

                if (sched.size() > 0) begin
                    if (sched[0].k == K_CLR) pix_pops = 0;
                    if (sched[0].k == K_DONE) begin
                        done_cyc  = cyc;
                        done_seen = 1'b1;
                    end
                    if (sched[0].k != K_ACC || bus.ofifo_valid) void'(sched.pop_front());
                end else if (bus.start) begin
                    build(bus.base_addr, bus.relu_cfg);
                    run_relu = bus.relu_cfg;
                    acc_cyc  = cyc + 1;
                end
            end
        end
    end

    task automatic fill(input bit neg_first);
        int s, x;
        for (int p = 0; p < NP; p++) begin
            s = 0;
            for (int t = 0; t < NT; t++) begin
                x = (neg_first && p == 0) ? negv[t] : int'($urandom_range(0, 200)) - 100;
                fifo_q.push_back(x);
                s += x;
            end
            exp_q.push_back(s);
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input bit relu);
        @(posedge clk); #1;
        n_wr = 0; n_pop = 0; done_seen = 1'b0;
        bus.base_addr = base;
        bus.relu_cfg  = relu;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && !done_seen; i++) @(posedge clk);
        chk(name, 32'(done_seen), 32'd1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.relu_cfg = 1'b0; bus.base_addr = '0; bus.ofifo_valid = 1'b0;
        bus1.start = 1'b0; bus1.relu_cfg = 1'b0; bus1.base_addr = '0; bus1.ofifo_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(outv()), 32'd0);
        chk("reset_state_small", 32'(outv1()), 32'd0);
        reset = 1'b1;

        // Full run, relu on, ofifo always valid.
        fill(1'b0);
        pulse_start(11'h100, 1'b1);
        wait_done("t1_done_timeout");
        chk("t1_writes", n_wr, 16);
        chk("t1_pops", n_pop, 144);
        chk("t1_first_wr_latency", first_wr_cyc - acc_cyc, 11);
        chk("t1_done_latency", done_cyc - acc_cyc, 192);
        chk("t1_last_addr", 32'(last_wr_addr), 32'h10F);

        // Negative-sum pixel with and without relu.
        fill(1'b1);
        pulse_start(11'h000, 1'b1);
        wait_done("t2a_done_timeout");
        chk("t2_relu_on_data", first_wr_data, 0);
        fill(1'b1);
        pulse_start(11'h000, 1'b0);
        wait_done("t2b_done_timeout");
        chk("t2_relu_off_data", first_wr_data, -37);

        // Randomly stalling ofifo.
        gate_rand = 1'b1;
        fill(1'b0);
        pulse_start(11'h3A5, 1'b1);
        wait_done("t3_done_timeout");
        chk("t3_pops", n_pop, 144);
        chk("t3_writes", n_wr, 16);

        // Asynchronous reset at tap 4 of pixel 3, then a fresh run.
        fill(1'b0);
        pulse_start(11'h200, 1'b0);
        for (int i = 0; i < 2000 && !(n_wr == 3 && pix_pops == 4); i++) begin
            @(posedge clk); #1;
        end
        chk("t4_reached_tap4_pix3", 32'(n_wr == 3 && pix_pops == 4), 32'd1);
        reset = 1'b0;
        #0.5;
        chk("t4_async_clear", 32'(outv()), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        gate_rand = 1'b0;
        @(posedge clk);
        fill(1'b0);
        pulse_start(11'h055, 1'b1);
        wait_done("t4_done_timeout");
        chk("t4_restart_writes", n_wr, 16);
        chk("t4_restart_latency", first_wr_cyc - acc_cyc, 11);

        // Address wrap and starts ignored while busy / in DONE.
        fill(1'b0);
        pulse_start(11'h7F8, 1'b0);
        repeat (30) @(posedge clk);
        #1 bus.start = 1'b1; bus.base_addr = 11'h123;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                bus.start = 1'b1;
                break;
            end
        end
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_extra_run", 32'(bus.busy), 32'd0);
        chk("t5_writes", n_wr, 16);
        chk("t5_wrapped_last_addr", 32'(last_wr_addr), 32'h007);

        // Single tap, single pixel instance: CLEAR, ACC, WRITE, DONE, IDLE.
        @(posedge clk); #1;
        bus1.base_addr = 11'h3FF; bus1.relu_cfg = 1'b0; bus1.start = 1'b1;
        @(posedge clk); #1 bus1.start = 1'b0;
        chk("t6_clear",  32'(outv1()), 32'({7'b1000010, 11'h000}));
        @(posedge clk); #1;
        chk("t6_acc",    32'(outv1()), 32'({7'b0101010, 11'h000}));
        @(posedge clk); #1;
        chk("t6_write",  32'(outv1()), 32'({7'b0000110, 11'h3FF}));
        @(posedge clk); #1;
        chk("t6_done",   32'(outv1()), 32'({7'b0000011, 11'h000}));
        @(posedge clk); #1;
        chk("t6_idle",   32'(outv1()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
